sram_axi_bridge: RTL and testbench

//  Converts the core's two SRAM-style ports (inst_sram_*, data_sram_*) into one AXI4 master, single beat, one outstanding txn.

---
 rtl/sram_axi_bridge_pkg.sv | 23 ++
 rtl/sram_axi_bridge_if.sv | 57 +++++
 rtl/sram_axi_bridge_wjoin.sv | 48 ++++
 rtl/sram_axi_bridge.sv | 199 +++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants, FSM encoding and small helpers for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_1BEAT  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // A data request with any byte strobe set is a store.
    function automatic logic is_store(input logic [7:0] we);
        return |we;
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Single-beat AXI4 master/slave bundle used between the bridge and the bus.
interface sram_axi_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic                  arvalid;
    logic [ADDR_W-1:0]     araddr;
    logic [ID_W-1:0]       arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arready;

    logic [DATA_W-1:0]     rdata;
    logic [ID_W-1:0]       rid;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic                  awvalid;
    logic [ADDR_W-1:0]     awaddr;
    logic [ID_W-1:0]       awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awready;

    logic                  wvalid;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wready;

    logic                  bvalid;
    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;
    logic                  bready;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
        input  rdata, rid, rresp, rlast, rvalid, output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bid, bresp, output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
        output rdata, rid, rresp, rlast, rvalid, input rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready
    );

endinterface

// File: rtl/sram_axi_bridge_wjoin.sv
// Runs the AW and W handshakes of one store in parallel; each valid drops on
// its own ready and both_ok_o flags the cycle in which the second one lands.
module sram_axi_wjoin (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic both_ok_o
);

    logic aw_ok_q, aw_ok_d;
    logic w_ok_q,  w_ok_d;
    logic aw_fire_s, w_fire_s;

    assign awvalid_o = active_i & ~aw_ok_q;
    assign wvalid_o  = active_i & ~w_ok_q;
    assign aw_fire_s = awvalid_o & awready_i;
    assign w_fire_s  = wvalid_o & wready_i;
    assign both_ok_o = active_i & (aw_ok_q | aw_fire_s) & (w_ok_q | w_fire_s);

    // Remember which half was accepted; clear once the pair is complete.
    always_comb begin
        aw_ok_d = aw_ok_q;
        w_ok_d  = w_ok_q;
        if (!active_i || both_ok_o) begin
            aw_ok_d = 1'b0;
            w_ok_d  = 1'b0;
        end else begin
            aw_ok_d = aw_ok_q | aw_fire_s;
            w_ok_d  = w_ok_q | w_fire_s;
        end
    end

    // Acceptance flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_ok_q <= 1'b0;
            w_ok_q  <= 1'b0;
        end else begin
            aw_ok_q <= aw_ok_d;
            w_ok_q  <= w_ok_d;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Serialises the core's fetch and data SRAM ports onto one single-beat AXI4
// master with one transaction in flight, holding the pipeline until both
// enabled requests are serviced, then releasing it for one cycle.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int INST_ID = 0,
    parameter int DATA_ID = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_sram_en,
    input  logic [7:0]        inst_sram_we,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic [DATA_W-1:0] inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [7:0]        data_sram_we,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              stallreq_axi,
    output logic              axi_err,
    sram_axi_bridge_if.master m_axi
);

    localparam logic [ID_W-1:0] INST_ID_L = ID_W'(INST_ID);
    localparam logic [ID_W-1:0] DATA_ID_L = ID_W'(DATA_ID);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   i_buf_q, i_buf_d;
    logic [DATA_W-1:0]   d_buf_q, d_buf_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;
    logic                err_q, err_d;
    logic                both_ok_s;
    logic                unused_s;

    // Fetch write strobes/data and the tail/ID of responses carry no information here.
    assign unused_s = ^{inst_sram_we, inst_sram_wdata, m_axi.rlast, m_axi.bid};

    sram_axi_wjoin u_wjoin (
        .clk       (clk),
        .rst_n     (rst_n),
        .active_i  (state_q == ST_WR_AW),
        .awready_i (m_axi.awready),
        .wready_i  (m_axi.wready),
        .awvalid_o (m_axi.awvalid),
        .wvalid_o  (m_axi.wvalid),
        .both_ok_o (both_ok_s)
    );

    // Request fields come from registers so they stay stable even if en drops.
    assign m_axi.arvalid = (state_q == ST_RD_A);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arid    = id_q;
    assign m_axi.arlen   = AXI_LEN_1BEAT;
    assign m_axi.arsize  = AXI_SIZE_8B;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.rready  = (state_q == ST_RD_D);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awid    = id_q;
    assign m_axi.awlen   = AXI_LEN_1BEAT;
    assign m_axi.awsize  = AXI_SIZE_8B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.bready  = (state_q == ST_WR_B);

    // Combinational so the pipeline freezes in the very cycle a request appears.
    assign stallreq_axi    = (inst_sram_en | data_sram_en) & (state_q != ST_DONE);
    assign inst_sram_rdata = i_buf_q;
    assign data_sram_rdata = d_buf_q;
    assign axi_err         = err_q;

    // Next-state, request capture, response buffering and error detection.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        id_d     = id_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        i_buf_d  = i_buf_q;
        d_buf_d  = d_buf_q;
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_sram_en && !d_done_q) begin
                    addr_d  = data_sram_addr;
                    id_d    = DATA_ID_L;
                    wdata_d = data_sram_wdata;
                    wstrb_d = data_sram_we;
                    if (is_store(data_sram_we)) begin
                        state_d = ST_WR_AW;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end else if (inst_sram_en && !i_done_q) begin
                    addr_d  = inst_sram_addr;
                    id_d    = INST_ID_L;
                    state_d = ST_RD_A;
                end else if (inst_sram_en || data_sram_en) begin
                    state_d = ST_DONE;
                end else begin
                    // Nothing requested: forget completions whose en went away.
                    i_done_d = 1'b0;
                    d_done_d = 1'b0;
                end
            end
            ST_RD_A: begin
                if (m_axi.arready) begin
                    state_d = ST_RD_D;
                end else begin
                    state_d = ST_RD_A;
                end
            end
            ST_RD_D: begin
                if (m_axi.rvalid && (m_axi.rid != id_q)) begin
                    // Stray beat: discard it and keep waiting for ours.
                    err_d = 1'b1;
                end else if (m_axi.rvalid) begin
                    err_d   = (m_axi.rresp != AXI_RESP_OKAY);
                    state_d = ST_IDLE;
                    if (m_axi.rid == DATA_ID_L) begin
                        d_buf_d  = m_axi.rdata;
                        d_done_d = 1'b1;
                    end else begin
                        i_buf_d  = m_axi.rdata;
                        i_done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RD_D;
                end
            end
            ST_WR_AW: begin
                if (both_ok_s) begin
                    state_d = ST_WR_B;
                end else begin
                    state_d = ST_WR_AW;
                end
            end
            ST_WR_B: begin
                if (m_axi.bvalid) begin
                    err_d    = (m_axi.bresp != AXI_RESP_OKAY);
                    d_done_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WR_B;
                end
            end
            ST_DONE: begin
                i_done_d = 1'b0;
                d_done_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 8'h00;
            i_buf_q  <= '0;
            d_buf_q  <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            i_buf_q  <= i_buf_d;
            d_buf_q  <= d_buf_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a vector table of single requests plus
// hand-written sequences for back-pressure, stray read IDs and mid-flight reset.
module tb_sram_axi_bridge;

    logic        clk;
    logic        rst_n;
    logic        inst_en;
    logic [7:0]  inst_we;
    logic [63:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_en;
    logic [7:0]  data_we;
    logic [63:0] data_addr, data_wdata, data_rdata;
    logic        stall, axi_err;

    int tests;
    int failed;

    // Slave behaviour knobs
    int          ar_delay, aw_delay, w_delay;
    logic [1:0]  rresp_cfg, bresp_cfg;
    logic [63:0] irsp, drsp;
    logic        hold_r;
    int          bad_rid_req;

    // Observations written only by the slave process
    int          ar_hs, aw_hs, w_hs, addr_hs, err_cnt, aw_only_cyc, awv_cyc, ar_unstable;
    logic [3:0]  id_log [64];
    logic [63:0] addr_log [64];
    logic [7:0]  wstrb_log;
    logic [63:0] wdata_log;

    sram_axi_bridge_if #(.ADDR_W(64), .DATA_W(64), .ID_W(4)) axi_if ();

    sram_axi_bridge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_sram_en    (inst_en),
        .inst_sram_we    (inst_we),
        .inst_sram_addr  (inst_addr),
        .inst_sram_wdata (inst_wdata),
        .inst_sram_rdata (inst_rdata),
        .data_sram_en    (data_en),
        .data_sram_we    (data_we),
        .data_sram_addr  (data_addr),
        .data_sram_wdata (data_wdata),
        .data_sram_rdata (data_rdata),
        .stallreq_axi    (stall),
        .axi_err         (axi_err),
        .m_axi           (axi_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // AXI slave model: acts on falling edges, handshakes complete on rising edges.
    initial begin : slave
        logic s_arv, s_rrdy, s_awv, s_wv, s_brdy, r_pend, b_pend, aw_got, w_got;
        logic [3:0]  r_tag, p_arid, p_awid;
        logic [63:0] p_araddr, p_awaddr, p_wdata;
        logic [7:0]  p_wstrb;
        int ar_wait, aw_wait, w_wait, bad_ack;
        s_arv = 1'b0; s_rrdy = 1'b0; s_awv = 1'b0; s_wv = 1'b0; s_brdy = 1'b0;
        r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        r_tag = 4'd0; p_arid = 4'd0; p_awid = 4'd0;
        p_araddr = 64'h0; p_awaddr = 64'h0; p_wdata = 64'h0; p_wstrb = 8'h00;
        ar_wait = 0; aw_wait = 0; w_wait = 0; bad_ack = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; addr_hs = 0; err_cnt = 0;
        aw_only_cyc = 0; awv_cyc = 0; ar_unstable = 0;
        wstrb_log = 8'h00; wdata_log = 64'h0;
        axi_if.arready = 1'b0; axi_if.awready = 1'b0; axi_if.wready = 1'b0;
        axi_if.rvalid = 1'b0; axi_if.rdata = 64'h0; axi_if.rid = 4'd0;
        axi_if.rresp = 2'b00; axi_if.rlast = 1'b0;
        axi_if.bvalid = 1'b0; axi_if.bid = 4'd0; axi_if.bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                ar_wait = 0; aw_wait = 0; w_wait = 0;
                axi_if.arready = 1'b0; axi_if.awready = 1'b0; axi_if.wready = 1'b0;
                axi_if.rvalid = 1'b0; axi_if.bvalid = 1'b0;
            end else begin
                if (s_arv && axi_if.arready) begin
                    ar_hs++;
                    id_log[addr_hs % 64] = p_arid;
                    addr_log[addr_hs % 64] = p_araddr;
                    addr_hs++;
                    r_pend = 1'b1;
                    r_tag = p_arid;
                end
                if (s_rrdy && axi_if.rvalid) axi_if.rvalid = 1'b0;
                if (s_awv && axi_if.awready) begin
                    aw_hs++;
                    id_log[addr_hs % 64] = p_awid;
                    addr_log[addr_hs % 64] = p_awaddr;
                    addr_hs++;
                    aw_got = 1'b1;
                end
                if (s_wv && axi_if.wready) begin
                    w_hs++;
                    wstrb_log = p_wstrb;
                    wdata_log = p_wdata;
                    w_got = 1'b1;
                end
                if (s_brdy && axi_if.bvalid) axi_if.bvalid = 1'b0;
                if (aw_got && w_got) begin
                    b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0;
                end
                if (axi_err) err_cnt++;
                if (axi_if.awvalid) awv_cyc++;
                if (axi_if.awvalid && !axi_if.wvalid) aw_only_cyc++;
                if (s_arv && axi_if.arvalid &&
                    (axi_if.araddr !== p_araddr || axi_if.arid !== p_arid)) ar_unstable++;
                axi_if.arready = axi_if.arvalid && (ar_wait >= ar_delay);
                ar_wait = axi_if.arvalid ? ar_wait + 1 : 0;
                axi_if.awready = axi_if.awvalid && (aw_wait >= aw_delay);
                aw_wait = axi_if.awvalid ? aw_wait + 1 : 0;
                axi_if.wready = axi_if.wvalid && (w_wait >= w_delay);
                w_wait = axi_if.wvalid ? w_wait + 1 : 0;
                if (r_pend && !axi_if.rvalid && !hold_r) begin
                    axi_if.rvalid = 1'b1;
                    axi_if.rlast  = 1'b1;
                    axi_if.rresp  = rresp_cfg;
                    if (bad_ack != bad_rid_req) begin
                        bad_ack = bad_rid_req;
                        axi_if.rid   = r_tag ^ 4'h1;
                        axi_if.rdata = 64'hDEAD_DEAD_DEAD_DEAD;
                    end else begin
                        axi_if.rid   = r_tag;
                        axi_if.rdata = (r_tag == 4'd0) ? irsp : drsp;
                        r_pend = 1'b0;
                    end
                end
                if (b_pend && !axi_if.bvalid) begin
                    axi_if.bvalid = 1'b1;
                    axi_if.bresp  = bresp_cfg;
                    axi_if.bid    = 4'd1;
                    b_pend = 1'b0;
                end
            end
            s_arv = axi_if.arvalid; s_rrdy = axi_if.rready; s_awv = axi_if.awvalid;
            s_wv = axi_if.wvalid; s_brdy = axi_if.bready;
            p_arid = axi_if.arid; p_araddr = axi_if.araddr;
            p_awid = axi_if.awid; p_awaddr = axi_if.awaddr;
            p_wstrb = axi_if.wstrb; p_wdata = axi_if.wdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one request, count stall cycles until release, sample rdata in the release cycle.
    task automatic do_req(input logic ie, input logic [63:0] ia, input logic de,
                          input logic [7:0] dwe, input logic [63:0] da, input logic [63:0] dwd,
                          output int stall_cyc, output logic [63:0] ird, output logic [63:0] drd);
        @(negedge clk);
        inst_en = ie; inst_addr = ia;
        data_en = de; data_we = dwe; data_addr = da; data_wdata = dwd;
        stall_cyc = 0;
        #1;
        while (stall && stall_cyc < 200) begin
            stall_cyc++;
            @(negedge clk);
            #1;
        end
        ird = inst_rdata;
        drd = data_rdata;
        inst_en = 1'b0; data_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic        ie;
        logic [63:0] ia;
        logic        de;
        logic [7:0]  we;
        logic [63:0] da;
        logic [63:0] dwd;
        logic [63:0] irsp;
        logic [63:0] drsp;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        int          exp_stall;
        logic [63:0] exp_ird;
        logic [63:0] exp_drd;
        int          exp_ar;
        int          exp_aw;
        int          exp_err;
        logic [3:0]  exp_id0;
        logic [63:0] exp_addr0;
        logic [3:0]  exp_id1;
        logic [63:0] exp_addr1;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int st, ar0, aw0, w0, e0, i0, awo0, awv0, aru0;
        logic [63:0] ird, drd;
        tests = 0; failed = 0;
        ar_delay = 0; aw_delay = 0; w_delay = 0;
        rresp_cfg = 2'b00; bresp_cfg = 2'b00; irsp = 64'h0; drsp = 64'h0;
        hold_r = 1'b0; bad_rid_req = 0;
        rst_n = 1'b0;
        inst_en = 1'b0; inst_we = 8'h00; inst_addr = 64'h0; inst_wdata = 64'h0;
        data_en = 1'b0; data_we = 8'h00; data_addr = 64'h0; data_wdata = 64'h0;

        vecs[0] = '{"fetch", 1'b1, 64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0,
                    64'h13, 64'h0, 2'b00, 2'b00, 4, 64'h13, 64'h0, 1, 0, 0,
                    4'd0, 64'h8000_0000, 4'd0, 64'h0, 8'h00, 64'h0};
        vecs[1] = '{"fetch_load", 1'b1, 64'h8000_0004, 1'b1, 8'h00, 64'h8000_1000, 64'h0,
                    64'hAAAA_0001, 64'hDDDD_0002, 2'b00, 2'b00, 7, 64'hAAAA_0001, 64'hDDDD_0002, 2, 0, 0,
                    4'd1, 64'h8000_1000, 4'd0, 64'h8000_0004, 8'h00, 64'h0};
        vecs[2] = '{"store", 1'b0, 64'h0, 1'b1, 8'hFF, 64'h8000_2000, 64'hCAFE,
                    64'h0, 64'h0, 2'b00, 2'b00, 4, 64'hAAAA_0001, 64'hDDDD_0002, 0, 1, 0,
                    4'd1, 64'h8000_2000, 4'd0, 64'h0, 8'hFF, 64'hCAFE};
        vecs[3] = '{"store_bslverr", 1'b0, 64'h0, 1'b1, 8'h03, 64'h8000_3000, 64'h55,
                    64'h0, 64'h0, 2'b00, 2'b10, 4, 64'hAAAA_0001, 64'hDDDD_0002, 0, 1, 1,
                    4'd1, 64'h8000_3000, 4'd0, 64'h0, 8'h03, 64'h55};
        vecs[4] = '{"load_rslverr", 1'b0, 64'h0, 1'b1, 8'h00, 64'h8000_4000, 64'h0,
                    64'h0, 64'h0BAD, 2'b10, 2'b00, 4, 64'hAAAA_0001, 64'h0BAD, 1, 0, 1,
                    4'd1, 64'h8000_4000, 4'd0, 64'h0, 8'h00, 64'h0};
        vecs[5] = '{"idle", 1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0,
                    64'h0, 64'h0, 2'b00, 2'b00, 0, 64'hAAAA_0001, 64'h0BAD, 0, 0, 0,
                    4'd0, 64'h0, 4'd0, 64'h0, 8'h00, 64'h0};
        vecs[6] = '{"fetch2", 1'b1, 64'h8000_0008, 1'b0, 8'h00, 64'h0, 64'h0,
                    64'h1234_5678_9ABC_DEF0, 64'h0, 2'b00, 2'b00, 4, 64'h1234_5678_9ABC_DEF0, 64'h0BAD, 1, 0, 0,
                    4'd0, 64'h8000_0008, 4'd0, 64'h0, 8'h00, 64'h0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_valids", {63'h0, axi_if.arvalid | axi_if.rready | axi_if.awvalid |
                             axi_if.wvalid | axi_if.bready}, 64'h0);
        chk("reset_stall", {63'h0, stall}, 64'h0);
        chk("reset_err", {63'h0, axi_err}, 64'h0);
        chk("reset_irdata", inst_rdata, 64'h0);
        chk("reset_drdata", data_rdata, 64'h0);

        for (int v = 0; v < 7; v++) begin
            irsp = vecs[v].irsp; drsp = vecs[v].drsp;
            rresp_cfg = vecs[v].rresp; bresp_cfg = vecs[v].bresp;
            ar0 = ar_hs; aw0 = aw_hs; e0 = err_cnt; i0 = addr_hs;
            do_req(vecs[v].ie, vecs[v].ia, vecs[v].de, vecs[v].we, vecs[v].da, vecs[v].dwd,
                   st, ird, drd);
            chk({vecs[v].name, "_stall"}, st, vecs[v].exp_stall);
            chk({vecs[v].name, "_ird"}, ird, vecs[v].exp_ird);
            chk({vecs[v].name, "_drd"}, drd, vecs[v].exp_drd);
            chk({vecs[v].name, "_ar_cnt"}, ar_hs - ar0, vecs[v].exp_ar);
            chk({vecs[v].name, "_aw_cnt"}, aw_hs - aw0, vecs[v].exp_aw);
            chk({vecs[v].name, "_err_cnt"}, err_cnt - e0, vecs[v].exp_err);
            if (vecs[v].exp_ar + vecs[v].exp_aw >= 1) begin
                chk({vecs[v].name, "_id0"}, id_log[i0 % 64], vecs[v].exp_id0);
                chk({vecs[v].name, "_addr0"}, addr_log[i0 % 64], vecs[v].exp_addr0);
            end
            if (vecs[v].exp_ar + vecs[v].exp_aw == 2) begin
                chk({vecs[v].name, "_id1"}, id_log[(i0 + 1) % 64], vecs[v].exp_id1);
                chk({vecs[v].name, "_addr1"}, addr_log[(i0 + 1) % 64], vecs[v].exp_addr1);
            end
            if (vecs[v].exp_aw > 0) begin
                chk({vecs[v].name, "_wstrb"}, wstrb_log, vecs[v].exp_wstrb);
                chk({vecs[v].name, "_wdata"}, wdata_log, vecs[v].exp_wdata);
            end
        end
        rresp_cfg = 2'b00; bresp_cfg = 2'b00;

        // Store where W is taken at once and AW only three cycles later.
        aw_delay = 3; w_delay = 0;
        aw0 = aw_hs; w0 = w_hs; awo0 = aw_only_cyc; awv0 = awv_cyc;
        do_req(1'b0, 64'h0, 1'b1, 8'h0F, 64'h8000_5000, 64'h1122_3344_5566_7788, st, ird, drd);
        chk("split_stall", st, 7);
        chk("split_aw_cnt", aw_hs - aw0, 1);
        chk("split_w_cnt", w_hs - w0, 1);
        chk("split_aw_only_cycles", aw_only_cyc - awo0, 3);
        chk("split_awvalid_cycles", awv_cyc - awv0, 4);
        chk("split_wstrb", wstrb_log, 8'h0F);
        chk("split_wdata", wdata_log, 64'h1122_3344_5566_7788);
        aw_delay = 0;

        // Long AR back-pressure: request must hold steady and stall stays high.
        ar_delay = 10; irsp = 64'h77;
        ar0 = ar_hs; aru0 = ar_unstable;
        do_req(1'b1, 64'h8000_0040, 1'b0, 8'h00, 64'h0, 64'h0, st, ird, drd);
        chk("arwait_stall", st, 14);
        chk("arwait_unstable", ar_unstable - aru0, 0);
        chk("arwait_ar_cnt", ar_hs - ar0, 1);
        chk("arwait_ird", ird, 64'h77);
        ar_delay = 0;

        // A stray RID beat is dropped with an error before the real response.
        bad_rid_req++; irsp = 64'h99;
        e0 = err_cnt;
        do_req(1'b1, 64'h8000_0080, 1'b0, 8'h00, 64'h0, 64'h0, st, ird, drd);
        chk("badrid_stall", st, 5);
        chk("badrid_err_cnt", err_cnt - e0, 1);
        chk("badrid_ird", ird, 64'h99);

        // Reset while waiting in the read-data phase.
        hold_r = 1'b1;
        @(negedge clk);
        inst_en = 1'b1; inst_addr = 64'h8000_0100;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pre_rready", {63'h0, axi_if.rready}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_arvalid", {63'h0, axi_if.arvalid}, 64'h0);
        chk("rst_rready", {63'h0, axi_if.rready}, 64'h0);
        chk("rst_stall_en_hi", {63'h0, stall}, 64'h1);
        chk("rst_irdata", inst_rdata, 64'h0);
        chk("rst_drdata", data_rdata, 64'h0);
        inst_en = 1'b0;
        #1;
        chk("rst_stall_en_lo", {63'h0, stall}, 64'h0);
        rst_n = 1'b1; hold_r = 1'b0;
        repeat (2) @(negedge clk);
        irsp = 64'h55;
        do_req(1'b1, 64'h8000_00C0, 1'b0, 8'h00, 64'h0, 64'h0, st, ird, drd);
        chk("post_rst_stall", st, 4);
        chk("post_rst_ird", ird, 64'h55);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
